// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: edge-detected capture of
// in_valid, DEPTH-entry circular buffer, first-word-fall-through drain and a
// sticky overflow flag for bytes dropped while full.
module uart_rx_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow,
    input  logic              clr_overflow
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ONE_PTR = ADDR_W'(1);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              in_valid_q;

    logic              wr_c;
    logic              rd_c;
    logic              accept_c;
    logic              drop_c;

    // Status and FWFT head are derived from the registered count/pointer.
    assign out_valid = (count != '0);
    assign full      = (count == FULL_CNT);
    assign out_data  = mem[rd_ptr];

    // Strobe generation: one write per rising edge of in_valid; a pop frees a
    // slot on the same edge so a write into a full FIFO is still accepted.
    always_comb begin
        wr_c     = 1'b0;
        rd_c     = 1'b0;
        accept_c = 1'b0;
        drop_c   = 1'b0;
        wr_c     = in_valid & ~in_valid_q;
        rd_c     = out_valid & out_ready;
        accept_c = wr_c & (~full | rd_c);
        drop_c   = wr_c & full & ~rd_c;
    end

    // Storage array; intentionally not reset.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers, occupancy, edge-detect history and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            in_valid_q <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            in_valid_q <= in_valid;
            if (accept_c) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            if (rd_c) begin
                rd_ptr <= rd_ptr + ONE_PTR;
            end
            if (accept_c && !rd_c) begin
                count <= count + ONE_CNT;
            end else if (rd_c && !accept_c) begin
                count <= count - ONE_CNT;
            end
            if (drop_c) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        in_data = '0;
    logic              in_valid = 1'b0;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              overflow;
    logic              clr_overflow = 1'b0;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic       m_prev = 1'b0;
    logic       m_ov   = 1'b0;

    uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .count        (count),
        .full         (full),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: FIFO as a queue, rules applied per clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_prev = 1'b0;
            m_ov   = 1'b0;
        end else begin
            logic wr, rd, drop;
            wr     = in_valid && !m_prev;
            m_prev = in_valid;
            rd     = (mq.size() > 0) && out_ready;
            drop   = wr && (mq.size() == DEPTH) && !rd;
            if (rd) void'(mq.pop_front());
            if (wr && !drop) mq.push_back(in_data);
            if (drop) m_ov = 1'b1;
            else if (clr_overflow) m_ov = 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("count", 32'(count), 32'(mq.size()));
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ov));
        if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        clr_overflow = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic push(input logic [7:0] b);
        in_data = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        // 1: single pulse, FWFT latency, pop
        do_reset();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        in_data = 8'hA5;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'hA5);
        chk("t1_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_pop_count", 32'(count), 32'd0);

        // 2: long in_valid level writes once
        in_data = 8'h3C;
        in_valid = 1'b1;
        repeat (5) step();
        in_valid = 1'b0;
        step();
        chk("t2_count", 32'(count), 32'd1);
        chk("t2_data", 32'(out_data), 32'h3C);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // 3: fill, overflow drop, ordered drain
        for (int i = 0; i < 16; i++) push(8'(i));
        push(8'hFF);
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_count", 32'(count), 32'd16);
        chk("t3_ovf", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t3_drain", 32'(out_data), 32'(i));
            step();
        end
        out_ready = 1'b0;
        chk("t3_empty", 32'(out_valid), 32'd0);

        // 6a: clear sticky overflow
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        chk("t6_clr", 32'(overflow), 32'd0);

        // 4: write into full FIFO while popping
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        in_data = 8'h77;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("t4_ovf", 32'(overflow), 32'd0);
        chk("t4_count", 32'(count), 32'd16);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("t4_last", 32'(out_data), 32'h77);
            else chk("t4_drain", 32'(out_data), 32'(8'h11 + i));
            step();
        end
        out_ready = 1'b0;

        // 6b: clear coinciding with a new drop keeps overflow set
        for (int i = 0; i < 16; i++) push(8'(8'hC0 + i));
        in_data = 8'h55;
        in_valid = 1'b1;
        clr_overflow = 1'b1;
        step();
        in_valid = 1'b0;
        clr_overflow = 1'b0;
        chk("t6_set_prio", 32'(overflow), 32'd1);
        step();

        // 6c: asynchronous reset with 5 entries
        do_reset();
        for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
        chk("t6_five", 32'(count), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("t6_async_count", 32'(count), 32'd0);
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // 5: randomized bursts with pointer wrap, model checked every cycle
        for (int i = 0; i < 600; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = 8'($urandom);
            out_ready = ($urandom_range(0, 3) == 0);
            clr_overflow = ($urandom_range(0, 15) == 0);
            step();
        end
        in_valid = 1'b0;
        clr_overflow = 1'b0;
        out_ready = 1'b1;
        repeat (20) step();
        out_ready = 1'b0;
        chk("t5_drained", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
